// File: rtl/box_painter.sv
// rtl/box_painter.sv - streams every pixel of NUM_BOX boxes, highlighting the box picked by direction
// Optional macro BOX_PAINTER_BORDER_EN: selected box gets a BORDER_COLOR perimeter around a HILITE_COLOR interior.
module box_painter #(
   parameter int                 NUM_BOX      = 4,
   parameter int                 BOX_W        = 4,
   parameter int                 BOX_H        = 4,
   parameter int                 X_W          = 8,
   parameter int                 Y_W          = 7,
   parameter int                 COLOR_W      = 3,
   parameter logic [COLOR_W-1:0] HILITE_COLOR = 3'b010,
   parameter logic [COLOR_W-1:0] IDLE_COLOR   = 3'b111,
   parameter logic [COLOR_W-1:0] BORDER_COLOR = 3'b100
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [2:0]                   direction,
   input  logic [NUM_BOX*(X_W+Y_W)-1:0] box_coords,
   output logic                         busy,
   output logic                         done,
   output logic                         plot,
   output logic [X_W-1:0]               out_x,
   output logic [Y_W-1:0]               out_y,
   output logic [COLOR_W-1:0]           out_color
);
   localparam int CW   = X_W + Y_W;
   localparam int PX_W = (BOX_W > 1) ? $clog2(BOX_W) : 1;
   localparam int PY_W = (BOX_H > 1) ? $clog2(BOX_H) : 1;
   localparam int BI_W = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1;
`ifdef BOX_PAINTER_BORDER_EN
   localparam bit BORDER_EN = 1'b1;
`else
   localparam bit BORDER_EN = 1'b0;
`endif

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DRAW = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]            state;
   logic [2:0]            dir_q;
   logic [NUM_BOX*CW-1:0] coords_q;
   logic [PX_W-1:0]       px;
   logic [PY_W-1:0]       py;
   logic [BI_W-1:0]       bi;

   logic [CW-1:0]         origin;
   logic                  px_last;
   logic                  py_last;
   logic                  bi_last;
   logic                  on_edge;
   logic [X_W-1:0]        pix_x;
   logic [Y_W-1:0]        pix_y;
   logic [COLOR_W-1:0]    pix_color;

   // Pixel generation works only from latched copies, so inputs may change freely mid-repaint.
   always_comb begin
      origin  = coords_q[int'(bi)*CW +: CW];
      px_last = (px == PX_W'(BOX_W - 1));
      py_last = (py == PY_W'(BOX_H - 1));
      bi_last = (bi == BI_W'(NUM_BOX - 1));
      on_edge = (px == '0) || px_last || (py == '0) || py_last;
      pix_x   = origin[CW-1 -: X_W] + X_W'(px);
      pix_y   = origin[Y_W-1:0] + Y_W'(py);
      if (32'(bi) == 32'(dir_q)) begin
         pix_color = (BORDER_EN && on_edge) ? BORDER_COLOR : HILITE_COLOR;
      end else begin
         pix_color = IDLE_COLOR;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         dir_q     <= '0;
         coords_q  <= '0;
         px        <= '0;
         py        <= '0;
         bi        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         plot      <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_color <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               plot <= 1'b0;
               done <= 1'b0;
               busy <= 1'b0;
               if (start) begin
                  state    <= S_DRAW;
                  busy     <= 1'b1;
                  dir_q    <= direction;
                  coords_q <= box_coords;
                  px       <= '0;
                  py       <= '0;
                  bi       <= '0;
               end
            end
            S_DRAW: begin
               plot      <= 1'b1;
               out_x     <= pix_x;
               out_y     <= pix_y;
               out_color <= pix_color;
               if (px_last) begin
                  px <= '0;
                  if (py_last) begin
                     py <= '0;
                     bi <= bi_last ? '0 : bi + 1'b1;
                     if (bi_last) begin
                        state <= S_DONE;
                     end
                  end else begin
                     py <= py + 1'b1;
                  end
               end else begin
                  px <= px + 1'b1;
               end
            end
            S_DONE: begin
               plot  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule
